pipelined_carry_select_adder: RTL

PIPELINED_CARRY_SELECT_ADDER -- requirements
Module: pipelined_carry_select_adder

---
 rtl/pipelined_carry_select_adder_pkg.sv | 15 +
 rtl/pipelined_carry_select_adder_cell.sv | 21 ++
 rtl/pipelined_carry_select_adder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pipelined_carry_select_adder_pkg.sv
// Index helpers for the triangular skew buffers of the pipelined carry-select adder.
// Operand segments still waiting and result segments already resolved are stored per stage.
package pipelined_carry_select_adder_pkg;

    // Slot of operand segment j (j > k) held in the register after stage k.
    function automatic int opq_idx(input int nseg, input int k, input int j);
        return k * (nseg - 1) - (k * (k - 1)) / 2 + (j - k - 1);
    endfunction

    // Slot of result segment j (j <= k) held in the register after stage k.
    function automatic int sum_idx(input int k, input int j);
        return (k * (k + 1)) / 2 + j;
    endfunction

endpackage

// File: rtl/pipelined_carry_select_adder_cell.sv
// Conditional-sum segment: forms both carry-in hypotheses and picks one with i_sel.
module carry_select_cell
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH:0] w_r0;
    logic [WIDTH:0] w_r1;

    assign w_r0 = {1'b0, i_a} + {1'b0, i_b};
    assign w_r1 = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign {o_cout, o_sum} = i_sel ? w_r1 : w_r0;

endmodule

// File: rtl/pipelined_carry_select_adder.sv
// Add/subtract pipeline resolving one SEG-bit segment per stage with a carry-select cell,
// operands skewed forward and results deskewed so the whole word leaves together.
module pipelined_carry_select_adder
    import pipelined_carry_select_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSEG = WIDTH / ((SEG >= 1) ? SEG : 1);
    localparam int NOP  = (NSEG > 1) ? NSEG * (NSEG - 1) / 2 : 1;
    localparam int NSM  = NSEG * (NSEG + 1) / 2;
    localparam int NPS  = (NSEG > 1) ? NSEG - 1 : 1;

    if (SEG < 1) begin : g_bad_seg
        $error("SEG must be at least 1");
    end else if (WIDTH % SEG != 0) begin : g_bad_width
        $error("WIDTH must be a multiple of SEG");
    end

    logic [SEG-1:0]   r_aq [NOP];
    logic [SEG-1:0]   r_bq [NOP];
    logic [SEG-1:0]   r_sq [NSM];
    logic [NSEG-1:0]  r_vld;
    logic [NSEG-1:0]  r_c;
    logic [NPS-1:0]   r_am;
    logic [NPS-1:0]   r_bm;
    logic             r_ovf;

    logic [WIDTH-1:0] w_beff;
    logic             w_cin0;
    logic             w_adv;
    logic             w_xfer;
    logic [SEG-1:0]   w_sa [NSEG];
    logic [SEG-1:0]   w_sb [NSEG];
    logic [SEG-1:0]   w_s  [NSEG];
    logic [NSEG-1:0]  w_ci;
    logic [NSEG-1:0]  w_co;
    logic [NSEG-1:0]  w_am;
    logic [NSEG-1:0]  w_bm;

    // Subtract folds into the operands here, so in-flight ops never look at sub again.
    assign w_beff   = b ^ {WIDTH{sub}};
    assign w_cin0   = sub | carry_in;
    assign w_adv    = out_ready || !r_vld[NSEG-1];
    assign w_xfer   = in_valid && w_adv;
    assign in_ready = w_adv;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign w_sa[k] = a[SEG-1:0];
            assign w_sb[k] = w_beff[SEG-1:0];
            assign w_ci[k] = w_cin0;
            assign w_am[k] = a[WIDTH-1];
            assign w_bm[k] = w_beff[WIDTH-1];
        end else begin : g_body
            assign w_sa[k] = r_aq[opq_idx(NSEG, k - 1, k)];
            assign w_sb[k] = r_bq[opq_idx(NSEG, k - 1, k)];
            assign w_ci[k] = r_c[k-1];
            assign w_am[k] = r_am[k-1];
            assign w_bm[k] = r_bm[k-1];
        end

        carry_select_cell #(.WIDTH(SEG)) u_cell (
            .i_a    (w_sa[k]),
            .i_b    (w_sb[k]),
            .i_sel  (w_ci[k]),
            .o_sum  (w_s[k]),
            .o_cout (w_co[k])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_c   <= '0;
            r_am  <= '0;
            r_bm  <= '0;
            r_ovf <= 1'b0;
            for (int i = 0; i < NOP; i++) begin
                r_aq[i] <= '0;
                r_bq[i] <= '0;
            end
            for (int i = 0; i < NSM; i++) r_sq[i] <= '0;
        end else if (w_adv) begin
            r_vld[0] <= w_xfer;
            for (int k = 1; k < NSEG; k++) r_vld[k] <= r_vld[k-1];
            r_c <= w_co;
            for (int k = 0; k < NSEG - 1; k++) begin
                r_am[k] <= w_am[k];
                r_bm[k] <= w_bm[k];
            end
            for (int j = 1; j < NSEG; j++) begin
                r_aq[opq_idx(NSEG, 0, j)] <= a[j*SEG +: SEG];
                r_bq[opq_idx(NSEG, 0, j)] <= w_beff[j*SEG +: SEG];
            end
            for (int k = 1; k < NSEG - 1; k++) begin
                for (int j = k + 1; j < NSEG; j++) begin
                    r_aq[opq_idx(NSEG, k, j)] <= r_aq[opq_idx(NSEG, k - 1, j)];
                    r_bq[opq_idx(NSEG, k, j)] <= r_bq[opq_idx(NSEG, k - 1, j)];
                end
            end
            for (int k = 0; k < NSEG; k++) begin
                r_sq[sum_idx(k, k)] <= w_s[k];
                for (int j = 0; j < k; j++) r_sq[sum_idx(k, j)] <= r_sq[sum_idx(k - 1, j)];
            end
            // Sign overflow needs only the MSBs, which rode along with the top segment.
            r_ovf <= (w_am[NSEG-1] == w_bm[NSEG-1]) && (w_s[NSEG-1][SEG-1] != w_am[NSEG-1]);
        end
    end

    always_comb begin
        sum = '0;
        for (int j = 0; j < NSEG; j++) sum[j*SEG +: SEG] = r_sq[sum_idx(NSEG - 1, j)];
    end

    assign out_valid = r_vld[NSEG-1];
    assign carry_out = r_c[NSEG-1];
    assign overflow  = r_ovf;

endmodule
